// File: rtl/romulator_pkg.sv
// Shared encodings for the RAM bus arbiter: bus owner codes, FSM states and
// the default character-bank select address.
package romulator_pkg;

   typedef enum logic [1:0] {
      OWN_LOADER = 2'd0,
      OWN_CPU    = 2'd1,
      OWN_DIAG   = 2'd2
   } owner_e;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_RUN,
      ST_HALT_PEND,
      ST_HALTED,
      ST_RESUME_PEND
   } state_e;

   localparam logic [15:0] BANK_ADDR_DEF = 16'hE84C;

endpackage

// File: rtl/phi2_edge_sync.sv
// Brings the asynchronous CPU clock into the clk domain and emits a one-cycle
// pulse on each synchronised falling edge.
module phi2_edge_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic phi2_i,
   output logic fall_o
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= phi2_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // s3 holds the previous synchronised level; pulse lands two clks after the pin edge
   assign fall_o = s3_q & ~s2_q;

endmodule

// File: rtl/ram_bus_arbiter.sv
// Arbitrates the shared RAM between flash loader, CPU and diagnostics, with
// CPU halt handshake, write protection and VRAM mirroring.
module ram_bus_arbiter
   import romulator_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter int                DATA_W    = 8,
   parameter int                VRAM_AW   = 11,
   parameter logic [ADDR_W-1:0] BANK_ADDR = ADDR_W'(BANK_ADDR_DEF),
   parameter int                STALL_CYC = 4096
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_done,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0]   ld_wdata,
   input  logic                ld_cs,
   input  logic                ld_we,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [DATA_W-1:0]   cpu_wdata,
   input  logic                cpu_cs,
   input  logic                cpu_we,
   input  logic                phi2,
   input  logic                diag_halt_req,
   input  logic [ADDR_W-1:0]   diag_addr,
   input  logic [DATA_W-1:0]   diag_wdata,
   input  logic                diag_cs,
   input  logic                diag_we,
   input  logic [ADDR_W-1:0]   wp_lo,
   input  logic [ADDR_W-1:0]   wp_hi,
   input  logic [ADDR_W-1:0]   vram_lo,
   input  logic [ADDR_W-1:0]   vram_hi,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_wdata,
   output logic                ram_cs,
   output logic                ram_we,
   output logic                data_oe,
   output logic                rdy,
   output logic                halted,
   output logic [1:0]          owner,
   output logic                vram_we,
   output logic [VRAM_AW-1:0]  vram_waddr,
   output logic                stall_err,
   output logic                wp_hit
);

   localparam int CNT_W = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_CYC - 1);

   state_e            state_q;
   owner_e            owner_q;
   logic              rdy_q, halted_q, stall_err_q, wp_hit_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              fall;
   logic              cpu_wp;
   logic              in_vram, is_bank;
   logic [ADDR_W-1:0] vram_span, vram_ofs;

   // Unsigned half-open window; lo >= hi naturally yields an empty window.
   function automatic logic in_window(input logic [ADDR_W-1:0] lo,
                                      input logic [ADDR_W-1:0] hi,
                                      input logic [ADDR_W-1:0] a);
      return (a >= lo) && (a < hi);
   endfunction

   phi2_edge_sync u_phi2_sync (
      .clk_i  (clk),
      .rst_ni (rst),
      .phi2_i (phi2),
      .fall_o (fall)
   );

   // Request is evaluated before fall in every state that looks at both.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_LOAD;
         owner_q     <= OWN_LOADER;
         rdy_q       <= 1'b0;
         halted_q    <= 1'b0;
         stall_err_q <= 1'b0;
         wp_hit_q    <= 1'b0;
         cnt_q       <= '0;
      end else begin
         if (cpu_wp) wp_hit_q <= 1'b1;
         case (state_q)
            ST_LOAD: begin
               if (load_done) begin
                  state_q <= ST_RUN;
                  owner_q <= OWN_CPU;
                  rdy_q   <= 1'b1;
               end
            end
            ST_RUN: begin
               if (diag_halt_req) begin
                  state_q <= ST_HALT_PEND;
                  rdy_q   <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            ST_HALT_PEND: begin
               if (fall) begin
                  state_q  <= ST_HALTED;
                  owner_q  <= OWN_DIAG;
                  halted_q <= 1'b1;
               end else if (cnt_q == CNT_LAST) begin
                  state_q     <= ST_HALTED;
                  owner_q     <= OWN_DIAG;
                  halted_q    <= 1'b1;
                  stall_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_HALTED: begin
               if (!diag_halt_req) state_q <= ST_RESUME_PEND;
            end
            ST_RESUME_PEND: begin
               if (diag_halt_req) begin
                  state_q <= ST_HALTED;
               end else if (fall) begin
                  state_q  <= ST_RUN;
                  owner_q  <= OWN_CPU;
                  rdy_q    <= 1'b1;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= ST_LOAD;
               owner_q  <= OWN_LOADER;
               rdy_q    <= 1'b0;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign cpu_wp = (owner_q == OWN_CPU) && cpu_cs && cpu_we &&
                   in_window(wp_lo, wp_hi, cpu_addr);

   always_comb begin
      ram_addr  = ld_addr;
      ram_wdata = ld_wdata;
      ram_cs    = ld_cs;
      ram_we    = ld_we;
      case (owner_q)
         OWN_CPU: begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_cs    = cpu_cs;
            ram_we    = cpu_we & ~cpu_wp;
         end
         OWN_DIAG: begin
            ram_addr  = diag_addr;
            ram_wdata = diag_wdata;
            ram_cs    = diag_cs;
            ram_we    = diag_we;
         end
         default: ;
      endcase
   end

   assign in_vram    = in_window(vram_lo, vram_hi, ram_addr);
   assign is_bank    = (ram_addr == BANK_ADDR);
   assign vram_span  = vram_hi - vram_lo - ADDR_W'(1);
   assign vram_ofs   = ram_addr - vram_lo;
   assign vram_we    = ram_we & (in_vram | is_bank);
   // The bank select register is mirrored into the last VRAM location.
   assign vram_waddr = is_bank ? vram_span[VRAM_AW-1:0] : vram_ofs[VRAM_AW-1:0];

   assign data_oe    = (owner_q == OWN_CPU) & cpu_cs & ~cpu_we;
   assign rdy        = rdy_q;
   assign halted     = halted_q;
   assign owner      = owner_q;
   assign stall_err  = stall_err_q;
   assign wp_hit     = wp_hit_q;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Directed bench for ram_bus_arbiter: a default-timeout instance plus a
// short-timeout instance sharing the same stimulus.
module tb_ram_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_done;
   logic [15:0] ld_addr, cpu_addr, diag_addr;
   logic [7:0]  ld_wdata, cpu_wdata, diag_wdata;
   logic        ld_cs, ld_we, cpu_cs, cpu_we, diag_cs, diag_we;
   logic        phi2, diag_halt_req;
   logic [15:0] wp_lo, wp_hi, vram_lo, vram_hi;

   logic [15:0] ram_addr, s_ram_addr;
   logic [7:0]  ram_wdata, s_ram_wdata;
   logic        ram_cs, ram_we, data_oe, rdy, halted, vram_we, stall_err, wp_hit;
   logic        s_ram_cs, s_ram_we, s_data_oe, s_rdy, s_halted, s_vram_we, s_stall_err, s_wp_hit;
   logic [1:0]  owner, s_owner;
   logic [10:0] vram_waddr, s_vram_waddr;

   int n_vec = 0;
   int n_err = 0;
   int n;

   always #5 clk = ~clk;

   ram_bus_arbiter #(.STALL_CYC(4096)) dut (
      .clk(clk), .rst(rst), .load_done(load_done),
      .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_cs(ld_cs), .ld_we(ld_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
      .phi2(phi2), .diag_halt_req(diag_halt_req),
      .diag_addr(diag_addr), .diag_wdata(diag_wdata), .diag_cs(diag_cs), .diag_we(diag_we),
      .wp_lo(wp_lo), .wp_hi(wp_hi), .vram_lo(vram_lo), .vram_hi(vram_hi),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_cs(ram_cs), .ram_we(ram_we),
      .data_oe(data_oe), .rdy(rdy), .halted(halted), .owner(owner),
      .vram_we(vram_we), .vram_waddr(vram_waddr), .stall_err(stall_err), .wp_hit(wp_hit)
   );

   ram_bus_arbiter #(.STALL_CYC(16)) dut_s (
      .clk(clk), .rst(rst), .load_done(load_done),
      .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_cs(ld_cs), .ld_we(ld_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
      .phi2(phi2), .diag_halt_req(diag_halt_req),
      .diag_addr(diag_addr), .diag_wdata(diag_wdata), .diag_cs(diag_cs), .diag_we(diag_we),
      .wp_lo(wp_lo), .wp_hi(wp_hi), .vram_lo(vram_lo), .vram_hi(vram_hi),
      .ram_addr(s_ram_addr), .ram_wdata(s_ram_wdata), .ram_cs(s_ram_cs), .ram_we(s_ram_we),
      .data_oe(s_data_oe), .rdy(s_rdy), .halted(s_halted), .owner(s_owner),
      .vram_we(s_vram_we), .vram_waddr(s_vram_waddr), .stall_err(s_stall_err), .wp_hit(s_wp_hit)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; load_done = 1'b0; phi2 = 1'b1; diag_halt_req = 1'b0;
      ld_addr = 16'hC123; ld_wdata = 8'h11; ld_cs = 1'b1; ld_we = 1'b1;
      cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_cs = 1'b0; cpu_we = 1'b0;
      diag_addr = 16'h0000; diag_wdata = 8'h00; diag_cs = 1'b0; diag_we = 1'b0;
      wp_lo = 16'hC000; wp_hi = 16'hD000; vram_lo = 16'h8000; vram_hi = 16'h8800;
      #2 rst = 1'b0;
      #20;

      // Reset state; loader owns the bus and its writes are never protected
      chk("rst_owner", owner, 0);
      chk("rst_rdy", rdy, 0);
      chk("rst_halted", halted, 0);
      chk("rst_stall_err", stall_err, 0);
      chk("rst_wp_hit", wp_hit, 0);
      chk("ld_ram_addr", ram_addr, 16'hC123);
      chk("ld_ram_we", ram_we, 1);
      chk("ld_data_oe", data_oe, 0);

      @(posedge clk); #1 rst = 1'b1;
      repeat (10) tick();
      chk("load_wait_owner", owner, 0);
      chk("load_wait_rdy", rdy, 0);
      load_done = 1'b1;
      tick();
      load_done = 1'b0; ld_cs = 1'b0; ld_we = 1'b0;
      chk("run_rdy", rdy, 1);
      chk("run_owner", owner, 1);
      chk("run_halted", halted, 0);

      // Write protect: hi=0 is an empty window under unsigned compare
      wp_hi = 16'h0000;
      cpu_addr = 16'hC123; cpu_wdata = 8'h5A; cpu_cs = 1'b1; cpu_we = 1'b1;
      #1;
      chk("wp_empty_ram_we", ram_we, 1);
      chk("cpu_ram_addr", ram_addr, 16'hC123);
      chk("cpu_ram_wdata", ram_wdata, 8'h5A);
      tick();
      chk("wp_empty_hit", wp_hit, 0);
      wp_hi = 16'hD000;
      #1;
      chk("wp_ram_we", ram_we, 0);
      chk("wp_vram_we", vram_we, 0);
      tick();
      chk("wp_hit", wp_hit, 1);
      cpu_we = 1'b0;
      #1;
      chk("cpu_read_data_oe", data_oe, 1);

      // VRAM mirror
      cpu_we = 1'b1; cpu_addr = 16'h8010;
      #1;
      chk("vram_we_in", vram_we, 1);
      chk("vram_waddr_in", vram_waddr, 16);
      cpu_addr = 16'hE84C;
      #1;
      chk("vram_we_bank", vram_we, 1);
      chk("vram_waddr_bank", vram_waddr, 2047);
      cpu_addr = 16'h8800;
      #1;
      chk("vram_we_hi_excl", vram_we, 0);
      cpu_cs = 1'b0; cpu_we = 1'b0;

      // Halt with phi2 stuck high: short instance times out, long one waits
      diag_halt_req = 1'b1;
      tick();
      chk("halt_req_rdy", rdy, 0);
      chk("halt_req_owner", owner, 1);
      repeat (15) tick();
      chk("stall_before", s_halted, 0);
      tick();
      chk("stall_halted", s_halted, 1);
      chk("stall_err", s_stall_err, 1);
      chk("stall_owner", s_owner, 2);
      chk("pend_halted", halted, 0);
      chk("pend_stall_err", stall_err, 0);

      phi2 = 1'b0;
      n = 0;
      while (!halted && n < 4) begin tick(); n++; end
      chk("fall_halted", halted, 1);
      chk("fall_owner", owner, 2);
      chk("fall_stall_err", stall_err, 0);

      // Diag writes into the protected window pass through
      diag_addr = 16'hC123; diag_wdata = 8'hA5; diag_cs = 1'b1; diag_we = 1'b1;
      cpu_cs = 1'b1; cpu_we = 1'b0;
      #1;
      chk("diag_ram_we", ram_we, 1);
      chk("diag_ram_addr", ram_addr, 16'hC123);
      chk("diag_ram_wdata", ram_wdata, 8'hA5);
      chk("diag_data_oe", data_oe, 0);
      diag_cs = 1'b0; diag_we = 1'b0; cpu_cs = 1'b0;

      // Resume, re-request, then resume on a fresh fall
      diag_halt_req = 1'b0;
      tick();
      chk("resume_pend_halted", halted, 1);
      chk("resume_pend_rdy", rdy, 0);
      diag_halt_req = 1'b1;
      tick();
      phi2 = 1'b1;
      repeat (3) tick();
      phi2 = 1'b0;
      repeat (4) tick();
      chk("rehalt_halted", halted, 1);
      chk("rehalt_owner", owner, 2);
      chk("rehalt_rdy", rdy, 0);
      diag_halt_req = 1'b0;
      tick();
      phi2 = 1'b1;
      repeat (3) tick();
      phi2 = 1'b0;
      n = 0;
      while (!rdy && n < 4) begin tick(); n++; end
      chk("resume_rdy", rdy, 1);
      chk("resume_owner", owner, 1);
      chk("resume_halted", halted, 0);

      // Halt with fall 20 cycles after the request
      phi2 = 1'b1;
      repeat (3) tick();
      diag_halt_req = 1'b1;
      tick();
      chk("halt2_rdy", rdy, 0);
      repeat (19) tick();
      chk("halt2_wait_halted", halted, 0);
      chk("halt2_wait_owner", owner, 1);
      phi2 = 1'b0;
      n = 0;
      while (!halted && n < 4) begin tick(); n++; end
      chk("halt2_halted", halted, 1);
      chk("halt2_owner", owner, 2);

      // Asynchronous reset mid-halt with the request still held
      rst = 1'b0;
      #1;
      chk("arst_owner", owner, 0);
      chk("arst_rdy", rdy, 0);
      chk("arst_halted", halted, 0);
      chk("arst_stall_err", s_stall_err, 0);
      chk("arst_wp_hit", wp_hit, 0);
      tick();
      tick();
      rst = 1'b1;
      repeat (3) tick();
      chk("reload_owner", owner, 0);
      chk("reload_rdy", rdy, 0);
      load_done = 1'b1;
      tick();
      load_done = 1'b0;
      chk("reload_run_rdy", rdy, 1);
      chk("reload_run_owner", owner, 1);
      tick();
      chk("pending_req_rdy", rdy, 0);
      chk("pending_req_halted", halted, 0);
      chk("pending_req_owner", owner, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
